// File: rtl/zap_wb_arbiter.sv
// N-master Wishbone arbiter: grants one master, muxes its *_nxt request onto the bus,
// registers that bus one cycle later and routes the slave ACK back to the granted master.
module zap_wb_arbiter #(
    parameter int  NUM_MASTERS    = 3,
    parameter int  ARB_MODE       = 0,
    parameter int  LOCK_EN        = 1,
    parameter int  LOCK_MAX_BEATS = 16,
    parameter int  ADR_WDT        = 32,
    parameter int  DAT_WDT        = 32,
    localparam int SEL_WDT        = DAT_WDT / 8,
    localparam int GNT_WDT        = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_MASTERS-1:0]         i_wb_cyc_nxt,
    input  logic [NUM_MASTERS-1:0]         i_wb_stb_nxt,
    input  logic [NUM_MASTERS-1:0]         i_wb_wen_nxt,
    input  logic [NUM_MASTERS*SEL_WDT-1:0] i_wb_sel_nxt,
    input  logic [NUM_MASTERS*DAT_WDT-1:0] i_wb_dat_nxt,
    input  logic [NUM_MASTERS*ADR_WDT-1:0] i_wb_adr_nxt,
    input  logic [NUM_MASTERS*3-1:0]       i_wb_cti_nxt,
    output logic [NUM_MASTERS-1:0]         o_wb_ack,
    output logic                           o_wb_cyc_nxt,
    output logic                           o_wb_stb_nxt,
    output logic                           o_wb_wen_nxt,
    output logic [SEL_WDT-1:0]             o_wb_sel_nxt,
    output logic [DAT_WDT-1:0]             o_wb_dat_nxt,
    output logic [ADR_WDT-1:0]             o_wb_adr_nxt,
    output logic [2:0]                     o_wb_cti_nxt,
    output logic                           o_wb_cyc,
    output logic                           o_wb_stb,
    output logic                           o_wb_wen,
    output logic [SEL_WDT-1:0]             o_wb_sel,
    output logic [DAT_WDT-1:0]             o_wb_dat,
    output logic [ADR_WDT-1:0]             o_wb_adr,
    output logic [2:0]                     o_wb_cti,
    input  logic                           i_wb_ack,
    output logic [GNT_WDT-1:0]             o_grant
);

    localparam int BCNT_WDT = (LOCK_MAX_BEATS > 0) ? $clog2(LOCK_MAX_BEATS + 1) : 1;

    typedef logic [GNT_WDT-1:0]  idx_t;
    typedef logic [BCNT_WDT-1:0] bcnt_t;

    idx_t  grant_ff, grant_nxt, prio_pick, rr_pick;
    bcnt_t beat_cnt;
    logic  boundary, other_req, limit_hit, locked;
    int    rr_dist, rr_best;

    // The round-robin pointer always equals grant_ff, so the search origin is grant_ff itself.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        boundary  = !o_wb_stb || i_wb_ack;
        other_req = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (k != int'(grant_ff) && i_wb_cyc_nxt[k]) other_req = 1'b1;
        limit_hit = (LOCK_MAX_BEATS != 0) && (int'(beat_cnt) >= LOCK_MAX_BEATS) && other_req;
        locked    = (LOCK_EN != 0) && i_wb_cyc_nxt[grant_ff] && !limit_hit;

        prio_pick = grant_ff;
        rr_pick   = grant_ff;
        rr_best   = NUM_MASTERS;
        rr_dist   = 0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (i_wb_cyc_nxt[k]) prio_pick = idx_t'(k);
        // Distance 0 is grant_ff+1; the current master sits at distance N-1 and is tried last.
        for (int k = 0; k < NUM_MASTERS; k++) begin
            rr_dist = (k + NUM_MASTERS - 1 - int'(grant_ff)) % NUM_MASTERS;
            if (i_wb_cyc_nxt[k] && rr_dist < rr_best) begin
                rr_best = rr_dist;
                rr_pick = idx_t'(k);
            end
        end

        grant_nxt = grant_ff;
        if (boundary && !locked)
            grant_nxt = (ARB_MODE == 0) ? prio_pick : rr_pick;
    end

    always_comb begin
        o_wb_cyc_nxt = 1'b0;
        o_wb_stb_nxt = 1'b0;
        o_wb_wen_nxt = 1'b0;
        o_wb_sel_nxt = '0;
        o_wb_dat_nxt = '0;
        o_wb_adr_nxt = '0;
        o_wb_cti_nxt = 3'b111;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (idx_t'(k) == grant_nxt) begin
                o_wb_cyc_nxt = i_wb_cyc_nxt[k];
                o_wb_stb_nxt = i_wb_stb_nxt[k];
                o_wb_wen_nxt = i_wb_wen_nxt[k];
                o_wb_sel_nxt = i_wb_sel_nxt[k*SEL_WDT +: SEL_WDT];
                o_wb_dat_nxt = i_wb_dat_nxt[k*DAT_WDT +: DAT_WDT];
                o_wb_adr_nxt = i_wb_adr_nxt[k*ADR_WDT +: ADR_WDT];
                o_wb_cti_nxt = i_wb_cti_nxt[k*3 +: 3];
            end
        end
    end

    // An ACK with no strobe outstanding, or one arriving under reset, belongs to nobody.
    always_comb begin
        o_wb_ack = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (idx_t'(k) == grant_ff) o_wb_ack[k] = i_wb_ack && o_wb_stb && !i_reset;
    end

    assign o_grant = grant_ff;

    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            grant_ff <= '0;
            beat_cnt <= '0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_sel <= '0;
            o_wb_dat <= '0;
            o_wb_adr <= '0;
            o_wb_cti <= 3'b111;
        end else begin
            grant_ff <= grant_nxt;
            if (grant_nxt != grant_ff || !i_wb_cyc_nxt[grant_ff])
                beat_cnt <= '0;
            else if (o_wb_stb && i_wb_ack && LOCK_MAX_BEATS != 0 && int'(beat_cnt) < LOCK_MAX_BEATS)
                beat_cnt <= beat_cnt + bcnt_t'(1);
            o_wb_cyc <= o_wb_cyc_nxt;
            o_wb_stb <= o_wb_stb_nxt;
            o_wb_wen <= o_wb_wen_nxt;
            o_wb_sel <= o_wb_sel_nxt;
            o_wb_dat <= o_wb_dat_nxt;
            o_wb_adr <= o_wb_adr_nxt;
            o_wb_cti <= o_wb_cti_nxt;
        end
    end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Bench for zap_wb_arbiter: four differently configured instances share one stimulus and
// are checked every cycle against a behavioural model, plus directed literal expectations.
module tb_zap_wb_arbiter;

    localparam int N  = 3;
    localparam int NI = 4;  // 0: prio/no lock, 1: round-robin/no lock, 2: prio/lock 16, 3: prio/lock 4

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        i_reset;
    logic        ack;
    logic [2:0]  cyc, stb, wen;
    logic [31:0] m_adr [N];
    logic [31:0] m_dat [N];
    logic [3:0]  m_sel [N];
    logic [2:0]  m_cti [N];
    logic [11:0] sel_p;
    logic [95:0] dat_p, adr_p;
    logic [8:0]  cti_p;

    always_comb begin
        sel_p = '0;
        dat_p = '0;
        adr_p = '0;
        cti_p = '0;
        for (int k = 0; k < N; k++) begin
            sel_p[k*4 +: 4]   = m_sel[k];
            dat_p[k*32 +: 32] = m_dat[k];
            adr_p[k*32 +: 32] = m_adr[k];
            cti_p[k*3 +: 3]   = m_cti[k];
        end
    end

    logic [2:0]  ack_o [NI];
    logic [1:0]  gnt_o [NI];
    logic        cyc_n [NI], stb_n [NI], wen_n [NI], cyc_r [NI], stb_r [NI], wen_r [NI];
    logic [3:0]  sel_n [NI], sel_r [NI];
    logic [31:0] dat_n [NI], dat_r [NI], adr_n [NI], adr_r [NI];
    logic [2:0]  cti_n [NI], cti_r [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        zap_wb_arbiter #(
            .NUM_MASTERS   (N),
            .ARB_MODE      (g == 1 ? 1 : 0),
            .LOCK_EN       (g >= 2 ? 1 : 0),
            .LOCK_MAX_BEATS(g == 3 ? 4 : 16),
            .ADR_WDT       (32),
            .DAT_WDT       (32)
        ) u_dut (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_wb_cyc_nxt(cyc),
            .i_wb_stb_nxt(stb),
            .i_wb_wen_nxt(wen),
            .i_wb_sel_nxt(sel_p),
            .i_wb_dat_nxt(dat_p),
            .i_wb_adr_nxt(adr_p),
            .i_wb_cti_nxt(cti_p),
            .o_wb_ack    (ack_o[g]),
            .o_wb_cyc_nxt(cyc_n[g]),
            .o_wb_stb_nxt(stb_n[g]),
            .o_wb_wen_nxt(wen_n[g]),
            .o_wb_sel_nxt(sel_n[g]),
            .o_wb_dat_nxt(dat_n[g]),
            .o_wb_adr_nxt(adr_n[g]),
            .o_wb_cti_nxt(cti_n[g]),
            .o_wb_cyc    (cyc_r[g]),
            .o_wb_stb    (stb_r[g]),
            .o_wb_wen    (wen_r[g]),
            .o_wb_sel    (sel_r[g]),
            .o_wb_dat    (dat_r[g]),
            .o_wb_adr    (adr_r[g]),
            .o_wb_cti    (cti_r[g]),
            .i_wb_ack    (ack),
            .o_grant     (gnt_o[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mode_of(input int i); return (i == 1) ? 1 : 0; endfunction
    function automatic int lock_of(input int i); return (i >= 2) ? 1 : 0; endfunction
    function automatic int max_of(input int i);  return (i == 3) ? 4 : 16; endfunction

    // Model state: who owns the bus, ACKs seen in the current lock, and the registered bus.
    int          st_grant [NI], nx_grant [NI];
    int          st_beats [NI], nx_beats [NI];
    logic [73:0] st_bus   [NI], nx_bus   [NI];
    bit          model_on = 0;

    initial forever begin
        @(negedge i_clk);
        if (model_on) begin
            for (int i = 0; i < NI; i++) begin
                int          g, gn;
                bit          others, bnd, lim, lck;
                logic [73:0] bus_nxt, dut_nxt, dut_reg;
                g      = st_grant[i];
                others = 0;
                for (int k = 0; k < N; k++) if (k != g && cyc[k]) others = 1;
                bnd = !st_bus[i][72] || ack;
                lim = (st_beats[i] >= max_of(i)) && others;
                lck = (lock_of(i) == 1) && cyc[g] && !lim;
                gn  = g;
                if (bnd && !lck) begin
                    if (mode_of(i) == 0) begin
                        for (int k = N - 1; k >= 0; k--) if (cyc[k]) begin gn = k; break; end
                    end else begin
                        for (int d = 1; d <= N; d++) if (cyc[(g + d) % N]) begin gn = (g + d) % N; break; end
                    end
                end
                bus_nxt = {cyc[gn], stb[gn], wen[gn], m_sel[gn], m_dat[gn], m_adr[gn], m_cti[gn]};
                dut_nxt = {cyc_n[i], stb_n[i], wen_n[i], sel_n[i], dat_n[i], adr_n[i], cti_n[i]};
                dut_reg = {cyc_r[i], stb_r[i], wen_r[i], sel_r[i], dat_r[i], adr_r[i], cti_r[i]};
                check($sformatf("i%0d grant", i), gnt_o[i], g);
                check($sformatf("i%0d ack", i), ack_o[i],
                      (ack && st_bus[i][72] && !i_reset) ? (3'b001 << g) : 3'b000);
                check($sformatf("i%0d nxt bus", i), dut_nxt, bus_nxt);
                check($sformatf("i%0d reg bus", i), dut_reg, st_bus[i]);
                nx_grant[i] = gn;
                nx_bus[i]   = bus_nxt;
                if (gn != g || !cyc[g])                                   nx_beats[i] = 0;
                else if (st_bus[i][72] && ack && st_beats[i] < max_of(i)) nx_beats[i] = st_beats[i] + 1;
                else                                                      nx_beats[i] = st_beats[i];
            end
        end
        @(posedge i_clk);
        if (i_reset) begin
            for (int i = 0; i < NI; i++) begin
                st_grant[i] = 0;
                st_beats[i] = 0;
                st_bus[i]   = {3'b000, 4'h0, 32'h0, 32'h0, 3'b111};
            end
            model_on = 1;
        end else if (model_on) begin
            for (int i = 0; i < NI; i++) begin
                st_grant[i] = nx_grant[i];
                st_beats[i] = nx_beats[i];
                st_bus[i]   = nx_bus[i];
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
    endtask

    task automatic set_m(input int k, input bit c, input bit s, input logic [31:0] a, input logic [2:0] t);
        cyc[k]   = c;
        stb[k]   = s;
        wen[k]   = k[0];
        m_adr[k] = a;
        m_dat[k] = a ^ 32'hA5A5_0000;
        m_sel[k] = 4'hF >> k;
        m_cti[k] = t;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        ack     = 1'b0;
        for (int k = 0; k < N; k++) set_m(k, 0, 0, 32'h0, 3'b111);
        step();
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        int acks0;
        int exp_seq [7] = '{0, 1, 2, 0, 1, 2, 0};
        i_reset = 1'b1;
        ack     = 1'b0;
        for (int k = 0; k < N; k++) set_m(k, 0, 0, 32'h0, 3'b111);
        do_reset();

        // Priority handover on an ACK, then ACK routing with and without a strobe outstanding.
        set_m(0, 1, 1, 32'h100, 3'b111);
        set_m(1, 1, 1, 32'h200, 3'b111);
        sample();
        check("t1 first pick adr_nxt", adr_n[0], 32'h200);
        step();
        set_m(2, 1, 1, 32'h300, 3'b111);
        ack = 1'b1;
        sample();
        check("t1 grant during m1 beat", gnt_o[0], 1);
        check("t1 ack to m1", ack_o[0], 3'b010);
        check("t1 handover adr_nxt", adr_n[0], 32'h300);
        step();
        stb[2] = 1'b0;
        sample();
        check("t1 grant after ack", gnt_o[0], 2);
        check("t1 registered adr", adr_r[0], 32'h300);
        check("t2 ack with stb", ack_o[0], 3'b100);
        step();
        sample();
        check("t2 ack without stb", ack_o[0], 3'b000);
        step();

        // Round-robin with every master requesting and every beat acknowledged.
        do_reset();
        for (int k = 0; k < N; k++) set_m(k, 1, 1, 32'h400 + 32'(k * 16), 3'b111);
        ack = 1'b1;
        for (int c = 0; c < 7; c++) begin
            sample();
            check($sformatf("t3 rr grant c%0d", c), gnt_o[1], exp_seq[c]);
            step();
        end

        // Locked 8-beat burst from master0 with master2 waiting from beat 2.
        do_reset();
        acks0 = 0;
        for (int c = 0; c < 10; c++) begin
            if (c <= 7) set_m(0, 1, 1, 32'h1000 + 32'(4 * c), (c == 7) ? 3'b111 : 3'b010);
            else        set_m(0, 0, 0, 32'h0, 3'b111);
            if (c >= 2) set_m(2, 1, 1, 32'h3000, 3'b111);
            ack = (c >= 1 && c <= 8);
            sample();
            if (ack_o[2][0]) acks0++;
            if (c == 8) begin
                check("t4 grant on last ack", gnt_o[2], 0);
                check("t4 handover adr_nxt", adr_n[2], 32'h3000);
            end
            if (c == 9) check("t4 grant after burst", gnt_o[2], 2);
            step();
        end
        check("t4 acks to m0", acks0, 8);

        // Lock beat limit of 4: master0 keeps cyc, issues single beats, master1 waits.
        do_reset();
        acks0 = 0;
        for (int c = 0; c < 10; c++) begin
            set_m(0, 1, (c % 2 == 0), 32'h5000 + 32'(c), 3'b111);
            set_m(1, 1, 1, 32'h6000, 3'b111);
            ack = (c % 2 == 1);
            sample();
            if (ack_o[3][0]) acks0++;
            if (c == 8) check("t5 grant before release", gnt_o[3], 0);
            if (c == 9) begin
                check("t5 grant after release", gnt_o[3], 1);
                check("t5 ack to m1", ack_o[3], 3'b010);
            end
            step();
        end
        check("t5 acks to m0", acks0, 4);

        // Reset in the middle of a locked burst.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_m(0, 1, 1, 32'h7000 + 32'(4 * c), 3'b010);
            set_m(2, 1, 1, 32'h8000, 3'b111);
            ack = (c >= 1);
            sample();
            step();
        end
        i_reset = 1'b1;
        sample();
        check("t6 ack under reset", ack_o[2], 3'b000);
        step();
        i_reset = 1'b0;
        sample();
        check("t6 cyc after reset", cyc_r[2], 1'b0);
        check("t6 stb after reset", stb_r[2], 1'b0);
        check("t6 cti after reset", cti_r[2], 3'b111);
        check("t6 grant after reset", gnt_o[2], 0);
        check("t6 ack after reset", ack_o[2], 3'b000);
        step();
        ack = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
